// File: rtl/oled_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// oled_ctrl_pkg
// Shared types and constants for the SSD1306-class OLED power/command
// controller: top-level state encoding, byte-sender sub-phase encoding,
// panel command bytes and the layout of the init/power-down command ROM.
// -----------------------------------------------------------------------------
package oled_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_PU_VDD,
        ST_PU_SEND,
        ST_PU_RES_LO,
        ST_PU_RES_HI,
        ST_PU_VBAT,
        ST_READY,
        ST_XFER,
        ST_PD_SEND,
        ST_PD_VBAT
    } oled_state_e;

    // Handshake phases of one byte towards spi_host.
    typedef enum logic [1:0] {
        SND_WAIT_RDY,
        SND_WAIT_CS_LO,
        SND_WAIT_CS_HI,
        SND_WAIT_DONE
    } snd_phase_e;

    localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
    localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
    localparam logic [7:0] CMD_PUMP_ENABLE   = 8'h14;
    localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
    localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
    localparam logic [7:0] CMD_CONTRAST      = 8'h81;
    localparam logic [7:0] CMD_CONTRAST_VAL  = 8'h0F;
    localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
    localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h20;
    localparam logic [7:0] CMD_DISP_ON       = 8'hAF;

    // Command ROM layout: three power-up groups followed by the power-down byte.
    localparam int STEP_W   = 4;
    localparam int GRP0_LEN = 1;   // display off before reset pulse
    localparam int GRP1_LEN = 4;   // charge pump + precharge before VBAT
    localparam int GRP2_LEN = 7;   // panel setup + display on after VBAT

    localparam logic [STEP_W-1:0] STEP_GRP0_END = STEP_W'(GRP0_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_GRP1_END = STEP_W'(GRP0_LEN + GRP1_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_GRP2_END = STEP_W'(GRP0_LEN + GRP1_LEN + GRP2_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_PD       = STEP_W'(GRP0_LEN + GRP1_LEN + GRP2_LEN);

endpackage

// File: rtl/oled_cmd_rom.sv
// -----------------------------------------------------------------------------
// oled_cmd_rom
// Combinational lookup of the panel command sequence.
//   step_i : index into the sequence (power-up groups, then power-down byte)
//   byte_o : command byte to send for this step
//   last_o : high when this step is the final byte of its group
// -----------------------------------------------------------------------------
module oled_cmd_rom
    import oled_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] step_i,
    output logic [7:0]        byte_o,
    output logic              last_o
);

    always_comb begin
        byte_o = CMD_DISP_OFF;
        last_o = 1'b1;
        case (step_i)
            4'd0:    begin byte_o = CMD_DISP_OFF;      last_o = 1'b1; end
            4'd1:    begin byte_o = CMD_CHARGE_PUMP;   last_o = 1'b0; end
            4'd2:    begin byte_o = CMD_PUMP_ENABLE;   last_o = 1'b0; end
            4'd3:    begin byte_o = CMD_PRECHARGE;     last_o = 1'b0; end
            4'd4:    begin byte_o = CMD_PRECHARGE_VAL; last_o = 1'b1; end
            4'd5:    begin byte_o = CMD_CONTRAST;      last_o = 1'b0; end
            4'd6:    begin byte_o = CMD_CONTRAST_VAL;  last_o = 1'b0; end
            4'd7:    begin byte_o = CMD_SEG_REMAP;     last_o = 1'b0; end
            4'd8:    begin byte_o = CMD_COM_SCAN_DEC;  last_o = 1'b0; end
            4'd9:    begin byte_o = CMD_COM_PINS;      last_o = 1'b0; end
            4'd10:   begin byte_o = CMD_COM_PINS_VAL;  last_o = 1'b0; end
            4'd11:   begin byte_o = CMD_DISP_ON;       last_o = 1'b1; end
            4'd12:   begin byte_o = CMD_DISP_OFF;      last_o = 1'b1; end
            default: begin byte_o = CMD_DISP_OFF;      last_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/oled_ctrl.sv
// -----------------------------------------------------------------------------
// oled_ctrl
// Power sequencing and command controller for an SSD1306-class OLED panel.
// Runs VDD -> reset pulse -> charge pump -> VBAT -> panel setup on power-up,
// then arbitrates spi_host between a user byte-write port and the
// display-off / VBAT-off / VDD-off power-down sequence.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   pwr_on_req_i               start power-up (honoured only in OFF)
//   pwr_off_req_i              start power-down (honoured only in READY)
//   wr_valid_i/wr_data_i/wr_dc_i, wr_ready_o   user byte handshake
//   init_done_o, busy_o        status
//   spi_start_o, spi_data_o    byte request to spi_host
//   spi_ready_i, spi_ncs_i     spi_host ready and chip-select monitor
//   dc_o, res_n_o, vdd_n_o, vbat_n_o   panel pins
// -----------------------------------------------------------------------------
module oled_ctrl
    import oled_ctrl_pkg::*;
#(
    parameter int DLY_1MS_CYCLES = 100000,
    parameter int VBAT_DLY_MS    = 100,
    parameter int RES_DLY_MS     = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwr_on_req_i,
    input  logic       pwr_off_req_i,
    input  logic       wr_valid_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_dc_i,
    output logic       wr_ready_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       spi_start_o,
    output logic [7:0] spi_data_o,
    input  logic       spi_ready_i,
    input  logic       spi_ncs_i,
    output logic       dc_o,
    output logic       res_n_o,
    output logic       vdd_n_o,
    output logic       vbat_n_o
);

    localparam logic [31:0] CYC_LAST = 32'(DLY_1MS_CYCLES - 1);

    oled_state_e       state_q;
    snd_phase_e        snd_q;
    logic [STEP_W-1:0] step_q;
    logic              vdd_n_q, vbat_n_q, res_n_q, dc_q, start_q;
    logic [7:0]        data_q;

    logic [31:0]       cyc_q, cyc_d, ms_q, ms_d;
    logic [31:0]       dly_ms_last;
    logic              in_dly, dly_done;

    logic [7:0]        rom_byte;
    logic              rom_last;

    oled_cmd_rom u_rom (
        .step_i (step_q),
        .byte_o (rom_byte),
        .last_o (rom_last)
    );

    // Delay length for the current wait state; counters idle at zero elsewhere,
    // so every wait starts from a clean count on entry.
    always_comb begin
        in_dly      = 1'b1;
        dly_ms_last = '0;
        case (state_q)
            ST_PU_VDD:                 dly_ms_last = 32'd0;
            ST_PU_RES_LO, ST_PU_RES_HI: dly_ms_last = 32'(RES_DLY_MS - 1);
            ST_PU_VBAT, ST_PD_VBAT:    dly_ms_last = 32'(VBAT_DLY_MS - 1);
            default:                   in_dly = 1'b0;
        endcase
    end

    assign dly_done = in_dly && (cyc_q == CYC_LAST) && (ms_q == dly_ms_last);

    always_comb begin
        cyc_d = cyc_q;
        ms_d  = ms_q;
        if (!in_dly || dly_done) begin
            cyc_d = '0;
            ms_d  = '0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            ms_d  = ms_q + 32'd1;
        end else begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            ms_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_OFF;
            snd_q    <= SND_WAIT_RDY;
            step_q   <= '0;
            vdd_n_q  <= 1'b1;
            vbat_n_q <= 1'b1;
            res_n_q  <= 1'b1;
            dc_q     <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (pwr_on_req_i) begin
                        state_q <= ST_PU_VDD;
                        vdd_n_q <= 1'b0;
                    end
                end

                ST_PU_VDD, ST_PU_RES_HI, ST_PU_VBAT: begin
                    if (dly_done) begin
                        state_q <= ST_PU_SEND;
                        snd_q   <= SND_WAIT_RDY;
                    end
                end

                ST_PU_RES_LO: begin
                    if (dly_done) begin
                        state_q <= ST_PU_RES_HI;
                        res_n_q <= 1'b1;
                    end
                end

                ST_PU_SEND, ST_PD_SEND, ST_XFER: begin
                    case (snd_q)
                        SND_WAIT_RDY: begin
                            // User bytes were latched into data_q on accept.
                            if (spi_ready_i) begin
                                start_q <= 1'b1;
                                if (state_q != ST_XFER) data_q <= rom_byte;
                                snd_q <= SND_WAIT_CS_LO;
                            end
                        end
                        SND_WAIT_CS_LO: if (!spi_ncs_i) snd_q <= SND_WAIT_CS_HI;
                        SND_WAIT_CS_HI: begin
                            if (spi_ncs_i) begin
                                start_q <= 1'b0;
                                snd_q   <= SND_WAIT_DONE;
                            end
                        end
                        SND_WAIT_DONE: begin
                            if (spi_ready_i) begin
                                snd_q <= SND_WAIT_RDY;
                                if (state_q == ST_XFER) begin
                                    state_q <= ST_READY;
                                end else if (!rom_last) begin
                                    step_q <= step_q + 1'b1;
                                end else if (state_q == ST_PD_SEND) begin
                                    state_q  <= ST_PD_VBAT;
                                    vbat_n_q <= 1'b1;
                                    step_q   <= '0;
                                end else if (step_q == STEP_GRP0_END) begin
                                    state_q <= ST_PU_RES_LO;
                                    res_n_q <= 1'b0;
                                    step_q  <= step_q + 1'b1;
                                end else if (step_q == STEP_GRP1_END) begin
                                    state_q  <= ST_PU_VBAT;
                                    vbat_n_q <= 1'b0;
                                    step_q   <= step_q + 1'b1;
                                end else begin
                                    state_q <= ST_READY;
                                    step_q  <= '0;
                                end
                            end
                        end
                        default: snd_q <= SND_WAIT_RDY;
                    endcase
                end

                ST_READY: begin
                    // Power-down wins over a user byte in the same cycle.
                    if (pwr_off_req_i) begin
                        state_q <= ST_PD_SEND;
                        snd_q   <= SND_WAIT_RDY;
                        step_q  <= STEP_PD;
                        dc_q    <= 1'b0;
                    end else if (wr_valid_i) begin
                        state_q <= ST_XFER;
                        snd_q   <= SND_WAIT_RDY;
                        data_q  <= wr_data_i;
                        dc_q    <= wr_dc_i;
                    end
                end

                ST_PD_VBAT: begin
                    if (dly_done) begin
                        state_q <= ST_OFF;
                        vdd_n_q <= 1'b1;
                    end
                end

                default: state_q <= ST_OFF;
            endcase
        end
    end

    assign wr_ready_o  = (state_q == ST_READY) && !pwr_off_req_i;
    assign init_done_o = (state_q == ST_READY) || (state_q == ST_XFER);
    assign busy_o      = (state_q != ST_OFF) && (state_q != ST_READY);
    assign spi_start_o = start_q;
    assign spi_data_o  = data_q;
    assign dc_o        = dc_q;
    assign res_n_o     = res_n_q;
    assign vdd_n_o     = vdd_n_q;
    assign vbat_n_o    = vbat_n_q;

endmodule

// File: tb/tb_oled_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oled_ctrl
// Directed bench for oled_ctrl with a behavioural spi_host and a scoreboard
// of expected {dc, byte} pairs.
// -----------------------------------------------------------------------------
module tb_oled_ctrl;

    localparam int D  = 10;
    localparam int VB = 3;
    localparam int RD = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwr_on = 1'b0;
    logic       pwr_off = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_dc = 1'b0;
    logic       wr_ready, init_done, busy, spi_start, dc, res_n, vdd_n, vbat_n;
    logic [7:0] spi_data;
    logic       spi_ready = 1'b1;
    logic       spi_ncs = 1'b1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         m_st = 0;
    int         m_cnt = 0;
    logic [8:0] m_cap = '0;
    logic       hold_rdy = 1'b0;

    always #5 clk = ~clk;

    oled_ctrl #(
        .DLY_1MS_CYCLES (D),
        .VBAT_DLY_MS    (VB),
        .RES_DLY_MS     (RD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pwr_on_req_i  (pwr_on),
        .pwr_off_req_i (pwr_off),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_dc_i       (wr_dc),
        .wr_ready_o    (wr_ready),
        .init_done_o   (init_done),
        .busy_o        (busy),
        .spi_start_o   (spi_start),
        .spi_data_o    (spi_data),
        .spi_ready_i   (spi_ready),
        .spi_ncs_i     (spi_ncs),
        .dc_o          (dc),
        .res_n_o       (res_n),
        .vdd_n_o       (vdd_n),
        .vbat_n_o      (vbat_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 32'({vdd_n, vbat_n, res_n, dc, spi_start, spi_data, wr_ready, init_done, busy}),
            32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'hAE});
        exp_q.push_back({1'b0, 8'h8D});
        exp_q.push_back({1'b0, 8'h14});
        exp_q.push_back({1'b0, 8'hD9});
        exp_q.push_back({1'b0, 8'hF1});
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b0, 8'h0F});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hC8});
        exp_q.push_back({1'b0, 8'hDA});
        exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b0, 8'hAF});
    endtask

    task automatic pulse_pwr_on();
        @(posedge clk); #1 pwr_on = 1'b1;
        @(posedge clk); #1 pwr_on = 1'b0;
    endtask

    task automatic wait_init_done(input string tag);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 3000) begin @(negedge clk); cnt++; end
        chk(tag, 32'(init_done), 32'd1);
    endtask

    // Offers one user byte and returns once it has been accepted (or timed out).
    task automatic send_user(input logic [7:0] b, input logic d);
        int cnt;
        @(posedge clk); #1 wr_valid = 1'b1; wr_data = b; wr_dc = d;
        cnt = 0;
        @(negedge clk);
        while (!wr_ready && cnt < 500) begin @(negedge clk); cnt++; end
        chk("wr_accept", 32'(wr_ready), 32'd1);
        @(posedge clk); #1 wr_valid = 1'b0;
    endtask

    // Behavioural spi_host: acts on the falling edge so the DUT sees stable inputs.
    always @(negedge clk) begin
        if (rst) begin
            m_st      = 0;
            spi_ready = 1'b1;
            spi_ncs   = 1'b1;
        end else begin
            case (m_st)
                0: begin
                    if (spi_start) begin
                        m_cap     = {dc, spi_data};
                        spi_ready = 1'b0;
                        m_st      = 1;
                        chk("wr_ready_during_xfer", 32'(wr_ready), 32'd0);
                        chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) chk("spi_byte", 32'(m_cap), 32'(exp_q.pop_front()));
                    end else begin
                        spi_ready = !hold_rdy;
                    end
                end
                1: begin
                    spi_ncs = 1'b0;
                    m_cnt   = 0;
                    m_st    = 2;
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == 8) begin
                        chk("byte_held", 32'({dc, spi_data}), 32'(m_cap));
                        spi_ncs = 1'b1;
                        m_st    = 3;
                    end
                end
                default: begin
                    if (!spi_start) begin
                        spi_ready = 1'b1;
                        m_st      = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        int cnt;
        int starts;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        @(posedge clk); #1 rst = 1'b0;

        // Power-up with a stray power-off request part way through
        push_init();
        pulse_pwr_on();
        @(negedge clk);
        chk("vdd_on", 32'(vdd_n), 32'd0);
        chk("busy_pu", 32'(busy), 32'd1);
        @(posedge clk); #1 pwr_off = 1'b1;
        @(posedge clk); #1 pwr_off = 1'b0;

        cnt = 0;
        while (res_n && cnt < 1000) begin @(negedge clk); cnt++; end
        chk("res_lo_seen", 32'(res_n), 32'd0);
        cnt = 0;
        while (!res_n && cnt < 100) begin @(negedge clk); cnt++; end
        chk("res_lo_len", 32'(cnt), 32'd10);

        cnt = 0;
        while (vbat_n && cnt < 1000) begin @(negedge clk); cnt++; end
        chk("vbat_on", 32'(vbat_n), 32'd0);
        cnt = 0;
        while (!spi_start && cnt < 200) begin @(negedge clk); cnt++; end
        chk("vbat_lead", 32'(cnt >= 30), 32'd1);
        chk("post_vbat_byte", 32'(spi_data), 32'h81);

        wait_init_done("init_done_1");
        chk("ready_after_init", 32'({busy, wr_ready}), 32'b01);
        chk("sb_drained_init", 32'(exp_q.size()), 32'd0);

        // Power-on request while READY must do nothing
        pulse_pwr_on();
        repeat (20) @(negedge clk);
        chk("pwr_on_in_ready", 32'({init_done, busy, vdd_n, vbat_n, spi_start}), 32'b10000);

        // Back-to-back user writes
        exp_q.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b0, 8'h3C});
        send_user(8'h55, 1'b1);
        send_user(8'h3C, 1'b0);
        cnt = 0;
        @(negedge clk);
        while (!wr_ready && cnt < 500) begin @(negedge clk); cnt++; end
        chk("b2b_done", 32'(wr_ready), 32'd1);
        chk("sb_drained_b2b", 32'(exp_q.size()), 32'd0);

        // spi_host not ready for 50 cycles ahead of a user byte
        hold_rdy = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b1, 8'hA5});
        send_user(8'hA5, 1'b1);
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_start) starts++;
        end
        chk("no_start_while_busy", 32'(starts), 32'd0);
        chk("data_held", 32'({dc, spi_data}), 32'({1'b1, 8'hA5}));
        hold_rdy = 1'b0;
        cnt = 0;
        while (!wr_ready && cnt < 500) begin @(negedge clk); cnt++; end
        chk("held_xfer_done", 32'(wr_ready), 32'd1);
        chk("sb_drained_hold", 32'(exp_q.size()), 32'd0);

        // Power-down with a simultaneous write: the write is refused
        exp_q.push_back({1'b0, 8'hAE});
        @(posedge clk); #1 pwr_off = 1'b1; wr_valid = 1'b1; wr_data = 8'h99; wr_dc = 1'b1;
        @(negedge clk);
        chk("wr_ready_pd_pending", 32'(wr_ready), 32'd0);
        @(posedge clk); #1 pwr_off = 1'b0; wr_valid = 1'b0;
        cnt = 0;
        while (!vbat_n && cnt < 500) begin @(negedge clk); cnt++; end
        chk("vbat_off", 32'(vbat_n), 32'd1);
        cnt = 0;
        while (!vdd_n && cnt < 200) begin @(negedge clk); cnt++; end
        chk("vbat_to_vdd_len", 32'(cnt), 32'd30);
        chk("off_status", 32'({busy, init_done, dc, res_n}), 32'b0001);
        chk("sb_drained_pd", 32'(exp_q.size()), 32'd0);

        // Reset while the fifth init byte is on the wire
        exp_q.push_back({1'b0, 8'hAE});
        exp_q.push_back({1'b0, 8'h8D});
        exp_q.push_back({1'b0, 8'h14});
        exp_q.push_back({1'b0, 8'hD9});
        exp_q.push_back({1'b0, 8'hF1});
        pulse_pwr_on();
        cnt = 0;
        while (!(spi_start && spi_data == 8'hF1) && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("fifth_byte_started", 32'({spi_start, spi_data}), 32'({1'b1, 8'hF1}));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("reset_mid_xfer");
        chk("sb_drained_rst", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // Fresh power-up after reset restarts from display-off
        push_init();
        pulse_pwr_on();
        wait_init_done("init_done_2");
        chk("sb_drained_init2", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oled_ctrl.md
Name: oled_ctrl

Overview:
Power-sequencing and command controller for the SSD1306-class OLED panel. It sits above spi_host and drives its byte handshake. It runs the panel power-up and init command sequence, then shares the spi_host between that sequence and a user byte-write port with a DC (command/data) flag. It also runs the power-down sequence on request.

Parameters:
DLY_1MS_CYCLES, 100000, clk_i cycles per 1 ms; minimum 2.
VBAT_DLY_MS, 100, ms wait after VBAT on/off.
RES_DLY_MS, 1, ms for each of the RES low and RES high phases.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
pwr_on_req_i  in  1  pulse or level; starts power-up from OFF
pwr_off_req_i  in  1  pulse or level; starts power-down from READY
wr_valid_i  in  1  user byte valid
wr_data_i  in  8  user byte
wr_dc_i  in  1  0=command, 1=display data
wr_ready_o  out  1  user byte accepted when valid&ready
init_done_o  out  1  high in READY and XFER
busy_o  out  1  high in any state except OFF and READY
spi_start_o  out  1  to spi_host send_start_i
spi_data_o  out  8  to spi_host send_data_i
spi_ready_i  in  1  from spi_host send_ready_o
spi_ncs_i  in  1  from spi_host nCS_o (transfer monitor)
dc_o  out  1  panel D/C pin
res_n_o  out  1  panel RES#, active low
vdd_n_o  out  1  logic supply enable, active low
vbat_n_o  out  1  panel supply enable, active low

Behaviour:
- Reset (async, any state, including mid-transfer): state=OFF; vdd_n_o=1, vbat_n_o=1, res_n_o=1, dc_o=0, spi_start_o=0, spi_data_o=0, wr_ready_o=0, init_done_o=0, busy_o=0; counters=0, step=0.
- Byte sender (SEND sub-phase, used by every command and user byte): wait spi_ready_i=1; then drive spi_data_o/dc_o and spi_start_o=1, holding data and dc stable; wait spi_ncs_i=0 (started); wait spi_ncs_i=1 (bits done); drop spi_start_o next cycle; wait spi_ready_i=1, then the byte is complete. dc_o changes only while spi_start_o=0.
- Delay unit: cycle counter 0..DLY_1MS_CYCLES-1 plus ms counter; a wait of N ms ends exactly N*DLY_1MS_CYCLES cycles after entry.
- Power-up from OFF on pwr_on_req_i=1:
  - PU_VDD: vdd_n_o=0, wait 1 ms.
  - Send 0xAE.
  - PU_RES_LO: res_n_o=0 for RES_DLY_MS.
  - PU_RES_HI: res_n_o=1 for RES_DLY_MS.
  - Send 0x8D,0x14,0xD9,0xF1.
  - PU_VBAT: vbat_n_o=0, wait VBAT_DLY_MS.
  - Send 0x81,0x0F,0xA1,0xC8,0xDA,0x20,0xAF.
  - Go to READY.
  - All init bytes are sent with dc_o=0. Step index selects the ROM byte; the ROM returns a last-in-group flag.
- READY: wr_ready_o=1 combinationally, only while no power-down request is pending. On valid&ready, capture data and dc and go to XFER; wr_ready_o=0 until the byte completes, then return to READY.
- Power-down, accepted only in READY: pwr_off_req_i has priority over wr_valid_i in the same cycle.
  - Send 0xAE.
  - PD_VBAT: vbat_n_o=1, wait VBAT_DLY_MS.
  - vdd_n_o=1, go to OFF.
- pwr_on_req_i outside OFF and pwr_off_req_i outside READY are ignored. A request arriving during XFER is not latched.
- Step and byte counters wrap only by explicit clear on group end; there is no modular wrap.

Decomposition:
- oled_ctrl_pkg: state enum oled_state_e, command byte constants (CMD_DISP_OFF=0xAE, CMD_DISP_ON=0xAF, etc.), init-group lengths.
- Sub-module oled_cmd_rom: step index in; byte and last-in-group flag out; purely combinational.
- oled_ctrl instantiates oled_cmd_rom and connects to spi_host externally.

Test Plan:
- DLY_1MS_CYCLES=10, VBAT_DLY_MS=3, RES_DLY_MS=1, pwr_on pulse, spi_host model -> vdd_n_o falls; SPI bytes in order AE,8D,14,D9,F1,81,0F,A1,C8,DA,20,AF with dc_o=0; res_n_o low exactly 10 cycles; vbat_n_o low at least 30 cycles before 0x81 starts; init_done_o=1 after 0xAF.
- READY, write 0x55 with dc=1 then 0x3C with dc=0 back-to-back -> two transfers in order; dc_o=1 then 0; wr_ready_o low during each transfer.
- READY, pwr_off_req_i and wr_valid_i in the same cycle -> write not accepted; 0xAE sent; vbat_n_o=1; 30 cycles later vdd_n_o=1; state OFF; busy_o=0.
- rst_i asserted while the 5th init byte is mid-transfer -> next cycle all outputs at reset values; a later pwr_on restarts from 0xAE.
- pwr_on_req_i during READY and pwr_off_req_i during power-up -> no effect on sequence or outputs.
- spi_ready_i held 0 for 50 cycles before a user byte -> spi_start_o stays 0 and data is held; transfer proceeds once ready rises.
